// File: rtl/sync_counter_pkg.sv
// Shared definitions for the synchronous counter family (up and down counters).
// Holds the control-state encoding and width-independent constants only;
// anything that depends on a counter width lives in the counter itself.
package sync_counter_pkg;

    // Control state shared by the loadable counters.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_t;

    // State entered on reset by every counter in the family.
    localparam cnt_state_t CNT_RESET_STATE = IDLE;

    // Level of the terminal-count pulse outside the terminal cycle.
    localparam logic CNT_DONE_IDLE = 1'b0;

endpackage : sync_counter_pkg

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter (timer).
// A load value (saturated to max_value) is captured into q and a reload
// register; enabled edges in RUN decrement q, and the step from 1 flags a
// one-cycle done pulse.
// Optional feature macro: SYNC_DOWN_COUNTER_AUTORELOAD_EN
//   defined     -> terminal step reloads q from the reload register, stays RUN
//   not defined -> terminal step clears q and returns to IDLE
// Valid configuration: 1 <= max_value <= 2**width - 1.
module sync_down_counter
    import sync_counter_pkg::*;
#(
    parameter int width     = 3,
    parameter int max_value = 7
) (
    input  logic             ck,
    input  logic             rst_s,
    input  logic             enb,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q,
    output logic             cnt_zero,
    output logic             done,
    output logic             busy
);

    localparam logic [width-1:0] MAX_Q = width'(max_value);
    localparam logic [width-1:0] ONE_Q = width'(1);

    cnt_state_t       state, state_nxt;
    logic [width-1:0] q_nxt;
    logic [width-1:0] reload, reload_nxt;
    logic             done_nxt;
    logic [width-1:0] load_val;

    // Saturate the requested start value so the count never exceeds max_value.
    assign load_val = (d > MAX_Q) ? MAX_Q : d;

    // Next-state, next-count and terminal-pulse decode; load beats enable.
    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        reload_nxt = reload;
        done_nxt   = CNT_DONE_IDLE;

        if (load) begin
            q_nxt      = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && enb) begin
            if (q == ONE_Q) begin
                done_nxt = 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
                q_nxt    = reload;
`else
                q_nxt     = '0;
                state_nxt = IDLE;
`endif
            end else if (q != '0) begin
                // q is never 0 in RUN; the guard keeps the decrement from
                // wrapping even if that invariant were ever broken.
                q_nxt = q - ONE_Q;
            end
        end
    end

    // State, count, reload and pulse registers; reset clears them at once.
    always_ff @(posedge ck or negedge rst_s) begin
        if (!rst_s) begin
            state  <= CNT_RESET_STATE;
            q      <= '0;
            reload <= '0;
            done   <= CNT_DONE_IDLE;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            reload <= reload_nxt;
            done   <= done_nxt;
        end
    end

    // busy is a straight decode of the state flop, so it is glitch-free.
    assign busy     = (state == RUN);
    assign cnt_zero = (q == '0);

endmodule : sync_down_counter

// File: doc/sync_down_counter.md
# sync_down_counter

Loadable synchronous down-counter (timer) that complements the team's up-counter. It is loaded with a start value and decrements on enabled clock edges. It flags terminal count with a one-cycle `done` pulse, then stops or reloads. Used wherever the design needs to count a programmed number of enabled events down to zero, e.g. timeouts and fixed-length intervals.

## Interface
Parameters:
- `width`, default 3: counter width in bits.
- `max_value`, default 7: largest loadable count. Must satisfy 1 ≤ `max_value` ≤ 2^`width`−1.

Ports (clock and reset first):
- `ck`  input  1  single clock, rising-edge.
- `rst_s`  input  1  reset, asynchronous, active-low; the polarity and synchronicity are fixed.
- `enb`  input  1  count enable, sampled on `ck` rising edge.
- `load`  input  1  load strobe, sampled on `ck` rising edge.
- `d`  input  `width`  load value.
- `q`  output  `width`  current count, registered.
- `cnt_zero`  output  1  combinational, high when `q` == 0.
- `done`  output  1  registered, one-cycle terminal-count pulse.
- `busy`  output  1  registered, high in state RUN.

## Operation
- State machine has two states: IDLE and RUN.
- Reset (`rst_s` low): takes effect immediately, regardless of `ck`.
  - `q` = 0, reload register = 0, `done` = 0, `busy` = 0, state = IDLE.
  - `cnt_zero` = 1.
- Load value: `v` = min(`d`, `max_value`).
- `load` high, any state:
  - `q` ← `v` and reload register ← `v`.
  - Next state is RUN if `v` ≠ 0, else IDLE.
  - `done` = 0.
  - `load` has priority over `enb`.
- IDLE, `load` low:
  - `q` holds; `enb` is ignored; `done` = 0.
- RUN, `load` low, `enb` low:
  - `q` holds; `done` = 0.
- RUN, `load` low, `enb` high, `q` > 1:
  - `q` ← `q` − 1; `done` = 0.
- RUN, `load` low, `enb` high, `q` == 1 (terminal step):
  - `done` ← 1 for exactly one cycle.
  - `q` and next state depend on the reload configuration (see Configuration).
- Arithmetic: unsigned, `width` bits. In RUN, `q` never decrements past 0, so no wrap below zero occurs.
- A `done` pulse is never asserted two cycles in a row, except with reload enabled and a reload value of 1.

## Timing
- Load latency: 1 cycle. `load` sampled at edge k gives `q` = `v` and `busy` = (`v` ≠ 0) after edge k.
- Count period: with `q` loaded to N, `done` rises after the N-th enabled edge.
  - Without reload, `q` = 0 at that same edge.
- `done` and the `q` transition are produced by the same edge, so they are cycle-aligned.
- `cnt_zero` follows `q` combinationally, with no extra latency.
- `load` coinciding with the terminal step: the load wins, no `done` pulse, and the counter restarts from `v`.
- Reset mid-count: the count is abandoned, no `done` is produced, and all outputs go to their reset values.

## Configuration
- Macro `SYNC_DOWN_COUNTER_AUTORELOAD_EN`.
- Defined:
  - Terminal step sets `q` ← reload register.
  - State stays RUN and `busy` stays 1.
  - `done` pulses once every N enabled edges until a new `load` or a reset.
- Not defined:
  - Terminal step sets `q` ← 0 and state ← IDLE.
  - `busy` ← 0 and `cnt_zero` goes high.
  - The reload register is written by `load` but has no other effect.

## Structure
- Shared package `sync_counter_pkg` holds:
  - `typedef enum logic {IDLE, RUN} cnt_state_t`.
  - Any width-independent constants used by the counter family.
- The block is a single module with no sub-module.
  - The saturation and decrement logic are small enough to stay inline.
  - It does not reuse `d_ff`, because that flop has an active-high reset and samples on the negative edge.

## Test plan
- Reset check: hold `rst_s` low with `enb`=1 and `load`=1, then release. Required: `q`=0, `cnt_zero`=1, `busy`=0, `done`=0; no counting until a `load`.
- Basic count, no reload: load `d`=5, then `enb`=1 continuously. Required:
  - `q` sequence 5,4,3,2,1,0.
  - `done`=1 only in the cycle `q` becomes 0.
  - `busy` falls at the same edge, and `q` stays 0 afterwards.
- Enable gating and saturation: load `d`=7 with `max_value`=5, then toggle `enb` 1,0,1,0. Required: `q`=5,4,4,3,3 and `done`=0 throughout.
- Load collision: load 3 and count to `q`=1, then assert `load` with `d`=2 together with `enb`. Required: `q`=2, no `done`, `busy`=1.
- With `SYNC_DOWN_COUNTER_AUTORELOAD_EN`: load 3 with `enb`=1. Required:
  - `q` cycles 3,2,1,3,2,1.
  - `done` pulses each time `q` changes from 1 to 3.
  - `busy` stays 1.
- Async reset mid-count: drop `rst_s` between edges while `q`=4. Required: `q`=0 immediately without waiting for `ck`, and no `done` pulse.
